// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the PC sequencer
package pc_sequencer_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } pc_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational next-PC priority selection
module pc_next_mux
  import pc_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            halt_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            stall_i,
  input  logic            fetch_fire_i,
  output logic [XLEN-1:0] pc_next_o,
  output logic            take_halt_o,
  output logic            take_trap_o,
  output logic            take_redirect_o,
  output logic            take_fetch_o
);

  // Priority: halt, misaligned redirect, aligned redirect, stall, accepted fetch.
  // A redirect wins over stall and over a fetch accepted in the same cycle.
  always_comb begin
    pc_next_o       = pc_i;
    take_halt_o     = 1'b0;
    take_trap_o     = 1'b0;
    take_redirect_o = 1'b0;
    take_fetch_o    = 1'b0;
    if (halt_i) begin
      take_halt_o = 1'b1;
    end else if (redirect_valid_i && !is_aligned(redirect_target_i)) begin
      take_trap_o = 1'b1;
    end else if (redirect_valid_i) begin
      take_redirect_o = 1'b1;
      pc_next_o       = redirect_target_i;
    end else if (stall_i) begin
      pc_next_o = pc_i;
    end else if (fetch_fire_i) begin
      take_fetch_o = 1'b1;
      pc_next_o    = pc_i + PC_STEP;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer feeding instruction fetch
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectTarget,
  input  logic            stall,
  input  logic            halt,
  input  logic            fetchReady,
  output logic            fetchValid,
  output logic [XLEN-1:0] fetchAddr,
  output logic [XLEN-1:0] outPCNext,
  output logic            flush,
  output logic            misaligned,
  output logic            halted
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] out_pc_next_q, out_pc_next_d;
  logic            flush_q, flush_d;
  logic            misaligned_q, misaligned_d;
  logic            halted_q, halted_d;

  logic [XLEN-1:0] mux_pc_next;
  logic            take_halt, take_trap, take_redirect, take_fetch;
  logic            run;

  assign run = (state_q == ST_RUN);

  pc_next_mux u_pc_next_mux (
    .pc_i              (pc_q),
    .halt_i            (halt),
    .redirect_valid_i  (redirectValid),
    .redirect_target_i (redirectTarget),
    .stall_i           (stall),
    .fetch_fire_i      (run & fetchReady),
    .pc_next_o         (mux_pc_next),
    .take_halt_o       (take_halt),
    .take_trap_o       (take_trap),
    .take_redirect_o   (take_redirect),
    .take_fetch_o      (take_fetch)
  );

  // Next-state and register updates; the mux decisions only apply in RUN.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_pc_next_d = out_pc_next_q;
    flush_d       = 1'b0;
    misaligned_d  = misaligned_q;
    halted_d      = halted_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (take_halt) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (take_trap) begin
          state_d      = ST_TRAP;
          misaligned_d = 1'b1;
        end else if (take_redirect) begin
          pc_d    = mux_pc_next;
          flush_d = 1'b1;
        end else if (take_fetch) begin
          pc_d          = mux_pc_next;
          out_pc_next_d = pc_q;
        end
      end
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      out_pc_next_q <= RESET_PC;
      flush_q       <= 1'b0;
      misaligned_q  <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_pc_next_q <= out_pc_next_d;
      flush_q       <= flush_d;
      misaligned_q  <= misaligned_d;
      halted_q      <= halted_d;
    end
  end

  assign fetchValid = run;
  assign fetchAddr  = pc_q;
  assign outPCNext  = out_pc_next_q;
  assign flush      = flush_q;
  assign misaligned = misaligned_q;
  assign halted     = halted_q;

endmodule
